// File: rtl/regfile_flags.sv
// ============================================================================
// Module   : regfile_flags
// Purpose  : 2R/1W register file (x0 hardwired to zero) plus registered ALU
//            zero flag. Optional write-to-read bypass: define REGFILE_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_flags #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              we3,
  input  logic [ADDR_W-1:0] wa3,
  input  logic [DATA_W-1:0] wd3,
  input  logic              flag_we,
  input  logic              zero_in,
  output logic              zero_q
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] w_regs [DEPTH];
  logic              w_wr_ok;
  logic              r_zero;

  assign w_wr_ok   = we3 && (wa3 != '0);
  assign w_regs[0] = '0;

  generate
    for (genvar gi = 1; gi < DEPTH; gi++) begin : g_reg
      logic [DATA_W-1:0] r_q;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_q <= '0;
        end else if (w_wr_ok && (wa3 == ADDR_W'(gi))) begin
          r_q <= wd3;
        end
      end

      assign w_regs[gi] = r_q;
    end
  endgenerate

`ifdef REGFILE_BYPASS_EN
  logic w_byp1;
  logic w_byp2;

  // w_wr_ok already excludes address 0, so x0 still reads as zero.
  assign w_byp1 = reset_n && w_wr_ok && (ra1 == wa3);
  assign w_byp2 = reset_n && w_wr_ok && (ra2 == wa3);
  assign rd1    = w_byp1 ? wd3 : w_regs[ra1];
  assign rd2    = w_byp2 ? wd3 : w_regs[ra2];
`else
  assign rd1 = w_regs[ra1];
  assign rd2 = w_regs[ra2];
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_zero <= 1'b0;
    end else if (flag_we) begin
      r_zero <= zero_in;
    end
  end

  assign zero_q = r_zero;

endmodule

`default_nettype wire
